// File: rtl/adc_capture_ctrl.sv
// adc_capture_ctrl: armed, length-bounded ADC capture into the sample FIFO with optional ch1 rising-threshold trigger
module adc_capture_ctrl #(
  parameter int DATA_W = 16,
  parameter int COUNT_W = 24
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  arm,
  input  logic                  abort,
  input  logic                  trig_mode,
  input  logic [DATA_W-1:0]     threshold,
  input  logic [COUNT_W-1:0]    capture_len,
  input  logic [DATA_W-1:0]     adc_data_1,
  input  logic [DATA_W-1:0]     adc_data_2,
  input  logic                  data_valid,
  input  logic                  fifo_prog_full,
  output logic                  fifo_wr_en,
  output logic [2*DATA_W-1:0]   fifo_din,
  output logic                  busy,
  output logic                  done,
  output logic                  overflow,
  output logic [COUNT_W-1:0]    sample_count
);
  typedef enum logic [1:0] {IDLE, WAIT_TRIG, CAPTURE, DONE} state_t;
  state_t state, state_nxt;
  logic signed [DATA_W-1:0] thr_q, prev_ch1;
  logic prev_vld;
  logic [COUNT_W-1:0] len_q;
  logic start, trig, consume, last;
  // state register
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else state <= state_nxt;
  end
  // trigger detection, sample consumption and next-state decode; abort outranks everything
  always_comb begin
    start = arm && !abort && (state == IDLE || state == DONE);
    trig = data_valid && prev_vld && (prev_ch1 < thr_q) && ($signed(adc_data_1) >= thr_q);
    consume = !abort && data_valid && (state == CAPTURE || (state == WAIT_TRIG && trig));
    last = consume && (sample_count + COUNT_W'(1) == len_q);
    state_nxt = abort ? IDLE :
                start ? (capture_len == '0 ? DONE : trig_mode ? WAIT_TRIG : CAPTURE) :
                last ? DONE :
                consume ? CAPTURE : state;
    busy = state == WAIT_TRIG || state == CAPTURE;
    done = state == DONE;
  end
  // record parameters, history sample, counter and registered FIFO write port
  always_ff @(posedge clk) begin
    if (reset) begin
      fifo_wr_en <= 1'b0;
      fifo_din <= '0;
      overflow <= 1'b0;
      sample_count <= '0;
      thr_q <= '0;
      len_q <= '0;
      prev_ch1 <= '0;
      prev_vld <= 1'b0;
    end else begin
      fifo_wr_en <= consume && !fifo_prog_full;
      if (consume && !fifo_prog_full) fifo_din <= {adc_data_1, adc_data_2};
      if (start) begin
        thr_q <= threshold;
        len_q <= capture_len;
        sample_count <= '0;
        overflow <= 1'b0;
        prev_vld <= 1'b0;
      end else begin
        if (consume) sample_count <= sample_count + COUNT_W'(1);
        if (consume && fifo_prog_full) overflow <= 1'b1;
        if (state == WAIT_TRIG && data_valid && !abort) begin
          prev_ch1 <= adc_data_1;
          prev_vld <= 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_adc_capture_ctrl.sv
// tb_adc_capture_ctrl: directed stimulus with a behavioural record model checked every cycle
module tb_adc_capture_ctrl;
  localparam int DW = 16;
  localparam int CW = 24;
  localparam int P_IDLE = 0, P_WAIT = 1, P_CAP = 2, P_DONE = 3;
  logic clk = 0, reset = 1, arm = 0, abort = 0, trig_mode = 0;
  logic [DW-1:0] threshold = '0, adc_data_1 = '0, adc_data_2 = '0;
  logic [CW-1:0] capture_len = '0;
  logic data_valid = 0, fifo_prog_full = 0;
  logic fifo_wr_en, busy, done, overflow;
  logic [2*DW-1:0] fifo_din;
  logic [CW-1:0] sample_count;
  int total = 0, bad = 0, ncyc = 0;
  bit chk_en = 0;
  int m_phase = P_IDLE, m_len = 0, exp_cnt = 0;
  bit m_have = 0, take, exp_wr = 0, exp_ovf = 0, exp_busy = 0, exp_done = 0;
  logic [2*DW-1:0] exp_din = '0;
  logic signed [DW-1:0] m_thr = '0, m_prev = '0;
  logic [2*DW-1:0] wlog[$];
  int wcyc[$];

  adc_capture_ctrl #(.DATA_W(DW), .COUNT_W(CW)) dut (
    .clk(clk), .reset(reset), .arm(arm), .abort(abort), .trig_mode(trig_mode),
    .threshold(threshold), .capture_len(capture_len), .adc_data_1(adc_data_1),
    .adc_data_2(adc_data_2), .data_valid(data_valid), .fifo_prog_full(fifo_prog_full),
    .fifo_wr_en(fifo_wr_en), .fifo_din(fifo_din), .busy(busy), .done(done),
    .overflow(overflow), .sample_count(sample_count)
  );

  always #5 clk = ~clk;

  task automatic check(string nm, logic [63:0] act, logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // record-level model: what each edge must produce from the inputs presented before it
  always @(posedge clk) begin
    exp_wr = 0;
    if (reset) begin
      m_phase = P_IDLE; exp_cnt = 0; exp_ovf = 0; m_have = 0; exp_din = '0;
    end else if (abort) m_phase = P_IDLE;
    else if (arm && (m_phase == P_IDLE || m_phase == P_DONE)) begin
      m_thr = threshold; m_len = int'(capture_len); exp_cnt = 0; exp_ovf = 0; m_have = 0;
      m_phase = m_len == 0 ? P_DONE : trig_mode ? P_WAIT : P_CAP;
    end else if (data_valid && (m_phase == P_WAIT || m_phase == P_CAP)) begin
      take = m_phase == P_CAP;
      if (m_phase == P_WAIT) begin
        take = m_have && m_prev < m_thr && $signed(adc_data_1) >= m_thr;
        m_prev = adc_data_1; m_have = 1;
      end
      if (take) begin
        exp_cnt++;
        if (fifo_prog_full) exp_ovf = 1;
        else begin exp_wr = 1; exp_din = {adc_data_1, adc_data_2}; end
        m_phase = exp_cnt == m_len ? P_DONE : P_CAP;
      end
    end
    exp_busy = m_phase == P_WAIT || m_phase == P_CAP;
    exp_done = m_phase == P_DONE;
  end

  // compare every output against the model, away from the active edge, and log writes
  always @(negedge clk) begin
    if (chk_en) begin
      check("wr_en", 64'(fifo_wr_en), 64'(exp_wr));
      if (exp_wr) check("din", 64'(fifo_din), 64'(exp_din));
      check("busy", 64'(busy), 64'(exp_busy));
      check("done", 64'(done), 64'(exp_done));
      check("overflow", 64'(overflow), 64'(exp_ovf));
      check("count", 64'(sample_count), 64'(exp_cnt));
    end
    if (fifo_wr_en === 1'b1) begin wlog.push_back(fifo_din); wcyc.push_back(ncyc); end
    ncyc++;
  end

  task automatic tick(); @(posedge clk); #1; endtask
  task automatic settle(); @(negedge clk); #1; endtask
  task automatic drv(bit v, int d1, int d2, bit pf = 0);
    data_valid = v; adc_data_1 = DW'(d1); adc_data_2 = DW'(d2); fifo_prog_full = pf;
  endtask
  task automatic do_arm(bit mode, int th, int len);
    arm = 1; trig_mode = mode; threshold = DW'(th); capture_len = CW'(len);
    tick(); arm = 0;
  endtask
  task automatic clr_log(); wlog.delete(); wcyc.delete(); endtask

  initial begin
    tick(); tick(); reset = 0; chk_en = 1;
    settle();
    check("rst_busy", 64'(busy), 0); check("rst_count", 64'(sample_count), 0);
    // immediate ramp, len 8
    clr_log(); drv(1, 15, 15); do_arm(0, 0, 8);
    for (int i = 0; i < 16; i++) begin drv(1, i, i); tick(); end
    settle();
    check("t1_nwr", 64'(wlog.size()), 8);
    check("t1_first", 64'(wlog[0]), 0);
    check("t1_last", 64'(wlog[7]), 64'h00070007);
    check("t1_contig", 64'(wcyc[7] - wcyc[0]), 7);
    check("t1_count", 64'(sample_count), 8);
    check("t1_done", 64'(done), 1);
    check("t1_ovf", 64'(overflow), 0);
    // threshold 100
    clr_log(); drv(0, 0, 0); do_arm(1, 100, 4);
    drv(1, 120, 1); tick(); drv(1, 50, 2); tick();
    settle(); check("t2_notrig", 64'(wlog.size()), 0); check("t2_wait", 64'(busy), 1);
    drv(1, 99, 3); tick(); drv(1, 100, 4); tick(); drv(1, 101, 5); tick();
    drv(1, 102, 6); tick(); drv(1, 103, 7); tick(); drv(0, 0, 0); tick();
    settle();
    check("t2_nwr", 64'(wlog.size()), 4);
    check("t2_first", 64'(wlog[0]), 64'h00640004);
    // signed threshold -5
    clr_log(); do_arm(1, -5, 1);
    drv(1, -10, 9); tick(); drv(1, -5, 8); tick(); drv(0, 0, 0); tick();
    settle();
    check("t3_nwr", 64'(wlog.size()), 1);
    check("t3_ch1", 64'(wlog[0]), 64'hFFFB0008);
    // 0x7FFF then 0x8000 against threshold 0x8000: no trigger
    clr_log(); do_arm(1, 32'h8000, 2);
    drv(1, 32'h7FFF, 1); tick(); drv(1, 32'h8000, 2); tick(); drv(0, 0, 0); tick();
    settle();
    check("t3b_nwr", 64'(wlog.size()), 0); check("t3b_busy", 64'(busy), 1);
    abort = 1; tick(); abort = 0; settle();
    check("t3b_abort", 64'(busy), 0);
    // backpressure on samples 3..4
    clr_log(); do_arm(0, 0, 10);
    for (int i = 0; i < 12; i++) begin drv(1, i, 100 + i, i == 3 || i == 4); tick(); end
    drv(0, 0, 0, 0); settle();
    check("t4_nwr", 64'(wlog.size()), 8);
    check("t4_count", 64'(sample_count), 10);
    check("t4_ovf", 64'(overflow), 1);
    check("t4_done", 64'(done), 1);
    // alternating valid
    clr_log(); do_arm(0, 0, 4);
    for (int i = 0; i < 8; i++) begin drv(i % 2 == 0, i, i); tick(); end
    drv(0, 0, 0); tick(); settle();
    check("t5_nwr", 64'(wlog.size()), 4);
    check("t5_span", 64'(wcyc[3] - wcyc[0]), 6);
    check("t5_count", 64'(sample_count), 4);
    // arm ignored mid-capture
    clr_log(); do_arm(0, 0, 6);
    drv(1, 1, 1); tick(); drv(1, 2, 2); do_arm(0, 0, 2);
    for (int i = 3; i < 9; i++) begin drv(1, i, i); tick(); end
    drv(0, 0, 0); settle();
    check("t6_nwr", 64'(wlog.size()), 6);
    check("t6_count", 64'(sample_count), 6);
    // abort beats arm
    arm = 1; abort = 1; capture_len = 3; tick(); arm = 0; abort = 0; settle();
    check("t6_ab_busy", 64'(busy), 0); check("t6_ab_done", 64'(done), 0);
    check("t6_ab_hold", 64'(sample_count), 6);
    // zero length
    clr_log(); drv(1, 5, 5); do_arm(0, 0, 0); settle();
    check("t6_z_done", 64'(done), 1); check("t6_z_nwr", 64'(wlog.size()), 0);
    drv(0, 0, 0);
    // back-to-back records with arm on the done cycle
    clr_log(); do_arm(0, 0, 2);
    drv(1, 1, 1); tick(); drv(1, 2, 2); tick();
    check("t7_done_edge", 64'(done), 1);
    do_arm(0, 0, 2); drv(1, 3, 3); tick(); drv(1, 4, 4); tick(); drv(0, 0, 0); settle();
    check("t7_nwr", 64'(wlog.size()), 4);
    check("t7_last", 64'(wlog[3]), 64'h00040004);
    // reset mid-capture
    do_arm(0, 0, 8);
    for (int i = 0; i < 3; i++) begin drv(1, i, i); tick(); end
    reset = 1; tick(); settle();
    check("t8_wr", 64'(fifo_wr_en), 0); check("t8_busy", 64'(busy), 0);
    check("t8_count", 64'(sample_count), 0); check("t8_din", 64'(fifo_din), 0);
    reset = 0; drv(0, 0, 0); tick(); tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/adc_capture_ctrl.md
# adc_capture_ctrl

Capture controller between the SYZYGY ADC deserializer output (`adc_data_1`, `adc_data_2`, `data_valid`) and the sample FIFO write port, running entirely in the `adc_data_clk` domain. It replaces free-running FIFO filling with armed, length-bounded records. A record starts either immediately or on a rising threshold crossing of channel 1. The block packs both channels into one 32-bit FIFO word and reports status back to the host.

## Interface
Parameters:
- `DATA_W`, 16: width of each ADC channel sample.
- `COUNT_W`, 24: width of the capture length and sample counter.

Ports:
- `clk`  in  1: `adc_data_clk`; all logic on rising edge.
- `reset`  in  1: synchronous, active-high.
- `arm`  in  1: one-cycle pulse that starts a record (from trigger-in endpoint).
- `abort`  in  1: one-cycle pulse that returns to IDLE.
- `trig_mode`  in  1: 0 = immediate, 1 = threshold on channel 1; sampled on `arm`.
- `threshold`  in  DATA_W: signed two's-complement level; sampled on `arm`.
- `capture_len`  in  COUNT_W: sample pairs per record; sampled on `arm`.
- `adc_data_1`, `adc_data_2`  in  DATA_W: channel samples, qualified by `data_valid`.
- `data_valid`  in  1: sample pair valid this cycle.
- `fifo_prog_full`  in  1: FIFO backpressure.
- `fifo_wr_en`  out  1: FIFO write strobe.
- `fifo_din`  out  2*DATA_W: `{adc_data_1, adc_data_2}`.
- `busy`  out  1: high in WAIT_TRIG or CAPTURE.
- `done`  out  1: level; high in DONE.
- `overflow`  out  1: sticky; a sample was dropped in the current record.
- `sample_count`  out  COUNT_W: sample pairs consumed in the current record.

## Operation
- States: IDLE, WAIT_TRIG, CAPTURE, DONE. Reset forces IDLE. Reset value of every output is 0.
- **IDLE / DONE, `arm`:**
  - Latch `trig_mode`, `threshold` and `capture_len`.
  - Clear `sample_count`, `overflow` and `done`.
  - If the latched length is 0, go to DONE.
  - Otherwise go to CAPTURE if mode = 0, or WAIT_TRIG if mode = 1.
- **`arm` in WAIT_TRIG or CAPTURE:** ignored.
- **`abort`:** goes to IDLE from any state, clears `busy` and `done`, and holds `sample_count` and `overflow`. If `abort` and `arm` arrive together, `abort` wins.
- **WAIT_TRIG:**
  - Holds a previous-sample register `prev_ch1` plus a valid flag. The flag is cleared on entry.
  - On each `data_valid` cycle, a trigger occurs when the flag is set, `prev_ch1 < threshold` and `adc_data_1 >= threshold`. Both comparisons are signed.
  - On a trigger, that same sample pair is the first one captured, and the state goes to CAPTURE.
  - On every `data_valid` cycle, `prev_ch1` is updated and the flag is set.
  - A first sample that is already at or above the threshold does not trigger.
- **CAPTURE:**
  - Each `data_valid` cycle consumes one pair and increments `sample_count`.
  - If `fifo_prog_full` = 0, write `fifo_din` with `fifo_wr_en` = 1.
  - If `fifo_prog_full` = 1, drop the pair (no write), set `overflow`, and still count it. Records are therefore time-contiguous: `capture_len` pairs of ADC time.
  - When `sample_count` reaches `capture_len`, go to DONE.
- **`sample_count`:** saturates at `capture_len` and never wraps. `capture_len` = 2^COUNT_W−1 is legal.
- **`data_valid` low:** nothing is consumed and the counter is held, in any state.

## Timing
- `fifo_wr_en` and `fifo_din` are registered: asserted in the cycle after the qualifying sample is presented, and high for exactly one cycle per written pair.
- **Immediate mode:** the first sample eligible for capture is the one presented in the cycle after `arm`. `busy` rises in the cycle after `arm`.
- **Threshold mode:** the triggering sample appears on `fifo_din` one cycle after it is presented.
- **`sample_count`:** updates in the same cycle as `fifo_wr_en` for that sample.
- **End of record:** `done` rises in the same cycle as the final sample's write strobe (or its drop slot), and `busy` falls in that cycle.
- **Back-to-back captures:** an `arm` in the cycle `done` rises is accepted. Sustained throughput is one pair per cycle, with no bubbles inside a record.
- **Reset mid-record:** reset in any cycle clears `fifo_wr_en` in the following cycle. No partial write is produced after reset.

## Test plan
- Immediate mode, `capture_len` = 8, `data_valid` always 1, ramp input 0..15 → exactly 8 writes of `{0,0}`..`{7,7}` on consecutive cycles; `done` = 1 in the cycle of the 8th write; `sample_count` = 8; `overflow` = 0.
- Threshold mode, `threshold` = 100, ch1 sequence 120, 50, 99, 100, 101 → no trigger on 120 (first sample); trigger on 100; the first written ch1 = 100.
- Signed threshold: `threshold` = −5, ch1 −10 then −5 → trigger on −5; ch1 0x7FFF then 0x8000 → no trigger.
- `fifo_prog_full` forced high for samples 3–4 of a 10-sample record → 8 writes; `sample_count` = 10; `overflow` = 1; `done` = 1.
- `data_valid` toggling 1,0,1,0 with `capture_len` = 4 → 4 writes spread over 8 cycles; `sample_count` holds on invalid cycles.
- `arm` mid-capture ignored; `abort` with `arm` in the same cycle → IDLE; `capture_len` = 0 → `done` the cycle after `arm` with 0 writes; reset mid-capture → `fifo_wr_en` = 0 and all outputs 0 next cycle.
